// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and default widths for the data-memory arbiter
package dmem_pkg;

  localparam int DMEM_ADDR_W = 32;
  localparam int DMEM_DATA_W = 64;

  typedef enum logic {
    IDLE    = 1'b0,
    RD_WAIT = 1'b1
  } dmem_state_e;

  typedef enum logic {
    OWN_CPU = 1'b0,
    OWN_EXT = 1'b1
  } dmem_owner_e;

endpackage

// File: rtl/dmem_starve_ctr.sv
// rtl/dmem_starve_ctr.sv - saturating count of consecutive denied EXT cycles
module dmem_starve_ctr
  import dmem_pkg::*;
#(
  parameter int MAX = 8,
  parameter int W   = $clog2(MAX + 1)
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic sat
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  assign sat = (cnt_q == W'(MAX));

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc && !sat) begin
      cnt_d = cnt_q + W'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/dmem_arbiter.sv
// rtl/dmem_arbiter.sv - CPU-priority arbiter for a single-ported data memory
module dmem_arbiter
  import dmem_pkg::*;
#(
  parameter int ADDR_W     = DMEM_ADDR_W,
  parameter int DATA_W     = DMEM_DATA_W,
  parameter int MEM_LAT    = 1,
  parameter int STARVE_MAX = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_stall,
  input  logic              ext_req,
  input  logic              ext_we,
  input  logic [ADDR_W-1:0] ext_addr,
  input  logic [DATA_W-1:0] ext_wdata,
  output logic              ext_gnt,
  output logic              ext_rvalid,
  output logic [DATA_W-1:0] ext_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [2:0] LAT_INIT = 3'(MEM_LAT);

  dmem_state_e       state_q, state_d;
  dmem_owner_e       owner_q, owner_d;
  logic [2:0]        lat_cnt_q, lat_cnt_d;
  logic [DATA_W-1:0] cpu_rdata_q, cpu_rdata_d;
  logic [DATA_W-1:0] ext_rdata_q, ext_rdata_d;
  logic              starve_sat;
  logic              rd_done;
  logic              can_grant;

  // The last RD_WAIT cycle delivers data and frees the memory for a new grant.
  assign rd_done   = (state_q == RD_WAIT) && (lat_cnt_q == 3'd1);
  assign can_grant = (state_q == IDLE) || rd_done;

  always_comb begin
    cpu_gnt = 1'b0;
    ext_gnt = 1'b0;
    if (can_grant) begin
      if (ext_req && starve_sat) begin
        ext_gnt = 1'b1;
      end else if (cpu_req) begin
        cpu_gnt = 1'b1;
      end else if (ext_req) begin
        ext_gnt = 1'b1;
      end
    end
  end

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    if (ext_gnt) begin
      mem_en    = 1'b1;
      mem_we    = ext_we;
      mem_addr  = ext_addr;
      mem_wdata = ext_wdata;
    end else if (cpu_gnt) begin
      mem_en    = 1'b1;
      mem_we    = cpu_we;
      mem_addr  = cpu_addr;
      mem_wdata = cpu_wdata;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    if (state_q == RD_WAIT) begin
      lat_cnt_d = lat_cnt_q - 3'd1;
      if (rd_done) begin
        state_d = IDLE;
      end
    end
    if (mem_en && !mem_we) begin
      state_d   = RD_WAIT;
      lat_cnt_d = LAT_INIT;
      owner_d   = ext_gnt ? OWN_EXT : OWN_CPU;
    end
  end

  assign cpu_rvalid = rd_done && (owner_q == OWN_CPU);
  assign ext_rvalid = rd_done && (owner_q == OWN_EXT);

  // Read data passes straight through on the valid cycle and is held afterwards.
  assign cpu_rdata_d = cpu_rvalid ? mem_rdata : cpu_rdata_q;
  assign ext_rdata_d = ext_rvalid ? mem_rdata : ext_rdata_q;
  assign cpu_rdata   = cpu_rdata_d;
  assign ext_rdata   = ext_rdata_d;

  assign cpu_stall = (cpu_req && !cpu_gnt)
                   || ((state_q == RD_WAIT) && (owner_q == OWN_CPU) && !cpu_rvalid);

  dmem_starve_ctr #(
    .MAX (STARVE_MAX)
  ) u_starve (
    .clk (clk),
    .rst (rst),
    .inc (ext_req && !ext_gnt),
    .clr (!ext_req || ext_gnt),
    .sat (starve_sat)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= OWN_CPU;
      lat_cnt_q   <= 3'd0;
      cpu_rdata_q <= '0;
      ext_rdata_q <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      lat_cnt_q   <= lat_cnt_d;
      cpu_rdata_q <= cpu_rdata_d;
      ext_rdata_q <= ext_rdata_d;
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb/tb_dmem_arbiter.sv - directed self-checking bench for dmem_arbiter
module tb_dmem_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        cpu_req, cpu_we, ext_req, ext_we;
  logic [31:0] cpu_addr, ext_addr;
  logic [63:0] cpu_wdata, ext_wdata, mem_rdata;

  logic        a_cpu_gnt, a_cpu_rvalid, a_cpu_stall, a_ext_gnt, a_ext_rvalid;
  logic        a_mem_en, a_mem_we;
  logic [31:0] a_mem_addr;
  logic [63:0] a_cpu_rdata, a_ext_rdata, a_mem_wdata;

  logic        b_cpu_gnt, b_cpu_rvalid, b_cpu_stall, b_ext_gnt, b_ext_rvalid;
  logic        b_mem_en, b_mem_we;
  logic [31:0] b_mem_addr;
  logic [63:0] b_cpu_rdata, b_ext_rdata, b_mem_wdata;

  logic [6:0]  a_flags, b_flags;
  assign a_flags = {a_cpu_gnt, a_ext_gnt, a_cpu_rvalid, a_ext_rvalid, a_cpu_stall, a_mem_en, a_mem_we};
  assign b_flags = {b_cpu_gnt, b_ext_gnt, b_cpu_rvalid, b_ext_rvalid, b_cpu_stall, b_mem_en, b_mem_we};

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(2), .STARVE_MAX(3)) u_dut_a (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(a_cpu_gnt), .cpu_rvalid(a_cpu_rvalid), .cpu_rdata(a_cpu_rdata), .cpu_stall(a_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(a_ext_gnt), .ext_rvalid(a_ext_rvalid), .ext_rdata(a_ext_rdata),
    .mem_en(a_mem_en), .mem_we(a_mem_we), .mem_addr(a_mem_addr), .mem_wdata(a_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  dmem_arbiter #(.ADDR_W(32), .DATA_W(64), .MEM_LAT(1), .STARVE_MAX(3)) u_dut_b (
    .clk(clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(b_cpu_gnt), .cpu_rvalid(b_cpu_rvalid), .cpu_rdata(b_cpu_rdata), .cpu_stall(b_cpu_stall),
    .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr), .ext_wdata(ext_wdata),
    .ext_gnt(b_ext_gnt), .ext_rvalid(b_ext_rvalid), .ext_rdata(b_ext_rdata),
    .mem_en(b_mem_en), .mem_we(b_mem_we), .mem_addr(b_mem_addr), .mem_wdata(b_mem_wdata),
    .mem_rdata(mem_rdata)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic idle_in();
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    ext_req = 1'b0; ext_we = 1'b0; ext_addr = '0; ext_wdata = '0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic sample();
    @(negedge clk);
  endtask

  task automatic do_reset();
    idle_in();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    idle_in();
    mem_rdata = '0;
    rst = 1'b1;

    // reset state
    sample();
    check("reset_flags", 64'(a_flags), 64'h0);
    check("reset_cpu_rdata", a_cpu_rdata, 64'h0);
    check("reset_ext_rdata", a_ext_rdata, 64'h0);
    check("reset_mem_addr", 64'(a_mem_addr), 64'h0);
    tick();
    rst = 1'b0;

    // idle for 10 cycles
    for (int i = 0; i < 10; i++) begin
      sample();
      check($sformatf("idle_flags_%0d", i), 64'(a_flags), 64'h0);
      tick();
    end

    // CPU store
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h100; cpu_wdata = 64'hDEAD;
    sample();
    check("store_flags", 64'(a_flags), 64'b1000011);
    check("store_addr", 64'(a_mem_addr), 64'h100);
    check("store_wdata", a_mem_wdata, 64'hDEAD);
    tick();

    // CPU load, MEM_LAT=2 on dut a
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h200;
    sample();
    check("load_t0_flags", 64'(a_flags), 64'b1000010);
    check("load_t0_addr", 64'(a_mem_addr), 64'h200);
    tick();
    idle_in();
    sample();
    check("load_t1_flags", 64'(a_flags), 64'b0000100);
    tick();
    mem_rdata = 64'h1234;
    sample();
    check("load_t2_flags", 64'(a_flags), 64'b0010000);
    check("load_t2_rdata", a_cpu_rdata, 64'h1234);
    tick();
    mem_rdata = 64'h5555;
    sample();
    check("load_t3_flags", 64'(a_flags), 64'h0);
    check("load_t3_rdata_hold", a_cpu_rdata, 64'h1234);
    tick();

    // contention with STARVE_MAX=3, both writing
    do_reset();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("cont_cpu_%0d", i), 64'(a_flags), 64'b1000011);
      tick();
    end
    sample();
    check("cont_ext_flags", 64'(a_flags), 64'b0100111);
    check("cont_ext_addr", 64'(a_mem_addr), 64'h20);
    tick();
    sample();
    check("cont_cpu_again", 64'(a_flags), 64'b1000011);
    tick();

    // EXT read, then CPU write request while the read is outstanding
    do_reset();
    ext_req = 1'b1; ext_we = 1'b0; ext_addr = 32'h40;
    sample();
    check("extrd_t0_flags", 64'(a_flags), 64'b0100010);
    tick();
    idle_in();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h80; cpu_wdata = 64'h77;
    mem_rdata = 64'hABCD;
    sample();
    check("extrd_lat1_flags", 64'(b_flags), 64'b1001011);
    check("extrd_lat1_rdata", b_ext_rdata, 64'hABCD);
    check("extrd_lat2_t1_flags", 64'(a_flags), 64'b0000100);
    tick();
    sample();
    check("extrd_lat2_t2_flags", 64'(a_flags), 64'b1001011);
    check("extrd_lat2_rdata", a_ext_rdata, 64'hABCD);
    check("extrd_lat2_addr", 64'(a_mem_addr), 64'h80);
    tick();

    // reset during RD_WAIT abandons the read and clears the starve count
    do_reset();
    mem_rdata = '0;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h300;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30;
    sample();
    check("rstrd_t0_flags", 64'(a_flags), 64'b1000010);
    tick();
    idle_in();
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h30;
    rst = 1'b1;
    sample();
    check("rstrd_in_reset_flags", 64'(a_flags), 64'b0100011);
    tick();
    idle_in();
    rst = 1'b0;
    mem_rdata = 64'h9999;
    sample();
    check("rstrd_after_flags", 64'(a_flags), 64'h0);
    check("rstrd_after_rdata", a_cpu_rdata, 64'h0);
    tick();
    sample();
    check("rstrd_after2_rvalid", 64'(a_cpu_rvalid), 64'h0);
    tick();
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 32'h10;
    ext_req = 1'b1; ext_we = 1'b1; ext_addr = 32'h20;
    for (int i = 0; i < 3; i++) begin
      sample();
      check($sformatf("rstrd_cont_cpu_%0d", i), 64'(a_flags), 64'b1000011);
      tick();
    end
    sample();
    check("rstrd_cont_ext", 64'(a_flags), 64'b0100111);
    tick();
    idle_in();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
